// File: rtl/pipe_field_vga.sv
// Scrolling multi-pipe playfield for the flappy VGA path: per-frame scroll, random-hole respawn,
// bird scoring, and a one-clock registered pixel hit test against the current pipe positions.
module pipe_field_vga #(
    parameter int          NUM_PIPES      = 3,
    parameter int          PIPE_WIDTH     = 30,
    parameter int          PIPE_HOLE_SIZE = 50,
    parameter int          PIPE_SPACING   = 120,
    parameter int          SCREEN_W       = 320,
    parameter int          SCREEN_H       = 240,
    parameter int          HOLE_MARGIN    = 20,
    parameter int          SPEED          = 1,
    parameter int          BIRD_X         = 80,
    parameter logic [2:0]  PIPE_COLOR     = 3'b101
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic [8:0] i_x,
    input  logic [7:0] i_y,
    output logic [2:0] o_rgb,
    output logic       o_draw_pipe,
    output logic       o_pipe_passed,
    output logic [7:0] o_score
);

    localparam logic [9:0] C_SPEED  = 10'(SPEED);
    localparam logic [9:0] C_WRAP   = 10'(NUM_PIPES * PIPE_SPACING - SPEED);
    localparam logic [9:0] C_PW     = 10'(PIPE_WIDTH);
    localparam logic [9:0] C_SW     = 10'(SCREEN_W);
    localparam logic [9:0] C_BIRD   = 10'(BIRD_X);
    localparam logic [8:0] C_HOLE   = 9'(PIPE_HOLE_SIZE);
    localparam int         H_MAX    = SCREEN_H - HOLE_MARGIN - PIPE_HOLE_SIZE;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // The clamp only matters for parameter sets that break the hole-range constraint.
    function automatic logic [7:0] hole_top(input logic [6:0] rnd);
        logic [8:0] t;
        t = 9'(HOLE_MARGIN) + {2'b00, rnd};
        if (t > 9'(H_MAX))
            t = 9'(H_MAX);
        return t[7:0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] s);
        return (s == 8'hFF) ? s : s + 8'd1;
    endfunction

    function automatic logic [9:0] init_right(input int i);
        return 10'(SCREEN_W + PIPE_WIDTH + i * PIPE_SPACING);
    endfunction

    function automatic logic [7:0] init_hole(input int i);
        return 8'(HOLE_MARGIN + 32 * i);
    endfunction

    logic [9:0]           r_right [NUM_PIPES];
    logic [7:0]           r_hole  [NUM_PIPES];
    logic [7:0]           r_lfsr;
    logic [7:0]           r_score;
    logic                 r_pipe_passed;
    logic [2:0]           r_rgb;
    logic                 r_draw;

    logic [9:0]           w_next_right [NUM_PIPES];
    logic [NUM_PIPES-1:0] w_respawn;
    logic [NUM_PIPES-1:0] w_col;
    logic [NUM_PIPES-1:0] w_row;
    logic                 w_any_cross;
    logic                 w_hit;
    logic                 w_scroll;
    logic [9:0]           w_x10;
    logic [8:0]           w_y9;
    logic [7:0]           w_new_hole;

    assign w_scroll   = i_frame_tick & i_enable & ~i_clear;
    assign w_x10      = {1'b0, i_x};
    assign w_y9       = {1'b0, i_y};
    assign w_new_hole = hole_top(r_lfsr[6:0]);

    always_comb begin
        w_any_cross = 1'b0;
        w_hit       = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_respawn[i]    = (r_right[i] < C_SPEED);
            w_next_right[i] = w_respawn[i] ? (r_right[i] + C_WRAP) : (r_right[i] - C_SPEED);
            w_col[i] = (w_x10 + C_PW >= r_right[i]) && (w_x10 < r_right[i]) && (w_x10 < C_SW);
            w_row[i] = (w_y9 < {1'b0, r_hole[i]}) || (w_y9 >= {1'b0, r_hole[i]} + C_HOLE);
            if (w_col[i] && w_row[i])
                w_hit = 1'b1;
            if (!w_respawn[i] && (r_right[i] >= C_BIRD) && (w_next_right[i] < C_BIRD))
                w_any_cross = 1'b1;
        end
    end

    // Free-running hole source; deliberately untouched by i_clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lfsr <= 8'hA5;
        else
            r_lfsr <= lfsr_next(r_lfsr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_right[i] <= init_right(i);
                r_hole[i]  <= init_hole(i);
            end
            r_score       <= 8'd0;
            r_pipe_passed <= 1'b0;
        end else if (i_clear) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_right[i] <= init_right(i);
                r_hole[i]  <= init_hole(i);
            end
            r_score       <= 8'd0;
            r_pipe_passed <= 1'b0;
        end else if (w_scroll) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_right[i] <= w_next_right[i];
                if (w_respawn[i])
                    r_hole[i] <= w_new_hole;
            end
            r_pipe_passed <= w_any_cross;
            if (w_any_cross)
                r_score <= sat_inc(r_score);
        end else begin
            r_pipe_passed <= 1'b0;
        end
    end

    // Pixel stage: hit computed from pre-update positions, registered once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb  <= 3'b000;
            r_draw <= 1'b0;
        end else if (i_clear) begin
            r_rgb  <= 3'b000;
            r_draw <= 1'b0;
        end else begin
            r_rgb  <= w_hit ? PIPE_COLOR : 3'b000;
            r_draw <= w_hit;
        end
    end

    assign o_rgb         = r_rgb;
    assign o_draw_pipe   = r_draw;
    assign o_pipe_passed = r_pipe_passed;
    assign o_score       = r_score;

endmodule

// File: tb/tb_pipe_field_vga.sv
// Directed bench for pipe_field_vga: reset, scroll/draw, freeze, scoring, respawn, saturation,
// clear collision and asynchronous mid-frame reset, with hand-derived expected values.
module tb_pipe_field_vga;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [8:0] x = 9'd0;
    logic [7:0] y = 8'd0;
    logic [2:0] rgb;
    logic       draw_pipe;
    logic       pipe_passed;
    logic [7:0] score;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_lfsr;
    logic [7:0] exp_h;

    pipe_field_vga dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_tick (frame_tick),
        .i_enable     (enable),
        .i_clear      (clear),
        .i_x          (x),
        .i_y          (y),
        .o_rgb        (rgb),
        .o_draw_pipe  (draw_pipe),
        .o_pipe_passed(pipe_passed),
        .o_score      (score)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, advances every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= 8'hA5;
        else
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; holds frame_tick for n rising edges.
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        x = 9'd29;
        y = 8'd0;
        @(negedge clk);
        check("rst_draw",  draw_pipe, 0);
        check("rst_rgb",   rgb, 0);
        check("rst_score", score, 0);
        check("rst_pass",  pipe_passed, 0);
        check("rst_r0",    dut.r_right[0], 350);
        check("rst_r2",    dut.r_right[2], 590);
        check("rst_h2",    dut.r_hole[2], 84);

        ticks(40);
        check("scroll_r0", dut.r_right[0], 310);
        check("scroll_h0", dut.r_hole[0], 20);
        x = 9'd280; y = 8'd0;
        @(negedge clk);
        check("draw_280",  draw_pipe, 1);
        check("rgb_280",   rgb, 5);
        x = 9'd310; y = 8'd0;
        @(negedge clk);
        check("draw_310",  draw_pipe, 0);
        check("rgb_310",   rgb, 0);
        x = 9'd290; y = 8'd30;
        @(negedge clk);
        check("draw_hole", draw_pipe, 0);

        enable = 1'b0;
        x = 9'd280; y = 8'd0;
        ticks(10);
        check("frz_r0",    dut.r_right[0], 310);
        check("frz_r1",    dut.r_right[1], 430);
        check("frz_score", score, 0);
        check("frz_draw",  draw_pipe, 1);
        check("frz_rgb",   rgb, 5);
        enable = 1'b1;

        ticks(230);
        check("pre_r0",    dut.r_right[0], 80);
        check("pre_pass",  pipe_passed, 0);
        check("pre_score", score, 0);
        ticks(1);
        check("cross_r0",    dut.r_right[0], 79);
        check("cross_pass",  pipe_passed, 1);
        check("cross_score", score, 1);
        @(negedge clk);
        check("pass_drop",   pipe_passed, 0);
        check("score_hold",  score, 1);

        ticks(79);
        check("edge_r0", dut.r_right[0], 0);
        exp_h = 8'd20 + {1'b0, m_lfsr[6:0]};
        ticks(1);
        check("resp_r0",    dut.r_right[0], 359);
        check("resp_h0",    dut.r_hole[0], exp_h);
        check("resp_h1",    dut.r_hole[1], 52);
        check("resp_space", (dut.r_right[1] + 360 - dut.r_right[0]) % 360, 120);
        check("resp_pass",  pipe_passed, 0);
        check("resp_score", score, 1);

        ticks(31000);
        check("sat_score", score, 255);

        clear = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        frame_tick = 1'b0;
        check("clr_r0",    dut.r_right[0], 350);
        check("clr_r1",    dut.r_right[1], 470);
        check("clr_h1",    dut.r_hole[1], 52);
        check("clr_score", score, 0);
        check("clr_pass",  pipe_passed, 0);
        check("clr_draw",  draw_pipe, 0);
        check("clr_lfsr",  dut.r_lfsr, m_lfsr);

        ticks(5);
        check("pre_rst_r0", dut.r_right[0], 345);
        #2 rst_n = 1'b0;
        #1;
        check("arst_r0",   dut.r_right[0], 350);
        check("arst_lfsr", dut.r_lfsr, 8'hA5);
        check("arst_draw", draw_pipe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_lfsr", dut.r_lfsr, m_lfsr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_field_vga.md
# pipe_field_vga

Multi-pipe playfield renderer for the flappy VGA path. Holds NUM_PIPES pipe obstacles, scrolls them left once per frame, respawns each pipe off the right edge with a pseudo-random hole when it leaves the screen, and counts pipes passed by the bird. Each pixel query (X, Y) from the VGA timing block gets a registered colour and a pipe-hit flag one clock later. The output feeds the pixel mux and the bird collision logic.

## Interface
- NUM_PIPES, 3: number of pipes, 1..4.
- PIPE_WIDTH, 30: pipe width in pixels.
- PIPE_HOLE_SIZE, 50: vertical gap height in pixels.
- PIPE_SPACING, 120: distance between consecutive pipe right edges.
- SCREEN_W, 320 / SCREEN_H, 240: visible area.
- HOLE_MARGIN, 20: minimum hole top. Constraint: HOLE_MARGIN+127+PIPE_HOLE_SIZE ≤ SCREEN_H-HOLE_MARGIN.
- SPEED, 1: pixels scrolled per FRAME_TICK, 1..7.
- BIRD_X, 80: bird column used for scoring.
- PIPE_COLOR, 3'b101: RGB of pipe pixels.
- CLK in 1: pixel clock.
- RST_N in 1: asynchronous, active-low reset.
- FRAME_TICK in 1: one-cycle pulse per frame, asserted during vertical blank.
- ENABLE in 1: scrolling allowed; low freezes positions.
- CLEAR in 1: synchronous restart of the playfield.
- X in 9: current pixel column.
- Y in 8: current pixel row.
- RGB out 3: pixel colour, registered.
- DRAW_PIPE out 1: 1 when the pixel is a pipe pixel, registered.
- PIPE_PASSED out 1: one-cycle pulse when any pipe crosses BIRD_X.
- SCORE out 8: pipes passed, saturates at 255.

## Operation
- Per-pipe state:
  - R_i: 10-bit unsigned right edge (exclusive).
  - H_i: 8-bit hole top.
- Reset and CLEAR values:
  - R_i = SCREEN_W + PIPE_WIDTH + i·PIPE_SPACING.
  - H_i = HOLE_MARGIN + 32·i.
  - SCORE = 0, PIPE_PASSED = 0, RGB = 0, DRAW_PIPE = 0.
- LFSR: 8 bits, x^8+x^6+x^5+x^4+1.
  - Reset seed 8'hA5.
  - Advances every clock.
  - Not affected by CLEAR.
  - Never reaches zero.
- Scroll, on a cycle with FRAME_TICK=1, ENABLE=1, CLEAR=0. For every pipe, in parallel:
  - If R_i ≥ SPEED: R_i ← R_i − SPEED.
  - Otherwise it respawns:
    - R_i ← R_i + NUM_PIPES·PIPE_SPACING − SPEED.
    - H_i ← HOLE_MARGIN + LFSR[6:0], using the LFSR value before this edge.
    - If several pipes respawn on the same tick, they all take the same H value.
  - Respawning keeps the spacing exact.
- Scoring:
  - A pipe crosses when, during a scroll, its old R_i ≥ BIRD_X and its new R_i < BIRD_X. A respawn is not a crossing.
  - PIPE_PASSED = 1 on the cycle after any crossing.
  - SCORE increments by 1 per scroll cycle with at least one crossing, saturating at 255.
- Hit test, per pipe:
  - Column: X + PIPE_WIDTH ≥ R_i and X < R_i and X < SCREEN_W. Use 10-bit arithmetic; clipping at the left edge is implicit.
  - Row: Y < H_i or Y ≥ H_i + PIPE_HOLE_SIZE, using a 9-bit sum.
  - hit = OR of all pipes.
- Pixel output:
  - DRAW_PIPE ← hit.
  - RGB ← PIPE_COLOR when hit, else 3'b000.
- Priority:
  - CLEAR overrides FRAME_TICK in the same cycle.
  - ENABLE=0 blocks scrolling and scoring. The pixel path still runs.

## Timing
- Pixel latency is 1 clock. RGB and DRAW_PIPE at edge n+1 reflect X, Y and pipe state sampled at edge n.
- The pixel path always uses pre-update state. A FRAME_TICK cycle's own pixel uses the old positions.
- PIPE_PASSED and SCORE update on the edge that performs the scroll. PIPE_PASSED lasts exactly one cycle.
- An RST_N assertion mid-frame clears all state immediately and asynchronously. The release edge is the first active edge.
- Back-to-back FRAME_TICK cycles each scroll; no minimum spacing is required.

## Test plan
- Reset defaults: release reset, query X=29, Y=0 → next cycle DRAW_PIPE=0, RGB=0; SCORE=0; pipe 0 right edge is 350, which is off screen.
- Scroll and draw: 40 ticks with ENABLE=1 → R_0=310. Query X=280, Y=0 → DRAW_PIPE=1, RGB=101. Query X=310, Y=0 → 0. Query X=290, Y=H_0+10 (inside the hole) → 0.
- Freeze: ENABLE=0 for 10 ticks → positions and SCORE unchanged, pixel output unchanged for the same X, Y.
- Score: tick until R_0 goes from 80 to 79 → PIPE_PASSED high for exactly 1 cycle, SCORE=1. Force 255 crossings → SCORE stays 255.
- Respawn: tick until R_0 < 1 → R_0 = 0 + 360 − 1 = 359. H_0 = 20 + LFSR[6:0] from the previous cycle, checked by the reference model. R_1 − R_0 stays consistent mod 360.
- Clear collision: CLEAR and FRAME_TICK in the same cycle → reset positions and SCORE=0, no scroll, LFSR continues its sequence.
